// File: rtl/mux4_scan_ctrl_pkg.sv
// Shared widths, state encodings and enable polarity for the mux4 scan controller.
package mux4_scan_ctrl_pkg;

   localparam int SEL_W  = 2;
   localparam int DATA_W = 4;

   localparam logic [SEL_W-1:0] SEL_LAST = 2'd3;

   // mux4 enable is active-low
   localparam logic ENABLE_ON  = 1'b0;
   localparam logic ENABLE_OFF = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int cnt_width(input int dwell);
      return (dwell > 1) ? $clog2(dwell) : 1;
   endfunction

endpackage

// File: rtl/mux4_scan_ctrl_dwell_timer.sv
// Dwell counter: counts run cycles and pulses tick on the last cycle of each dwell.
module dwell_timer
   import mux4_scan_ctrl_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam int              CNT_W  = cnt_width(DWELL);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] r_cnt;

   assign tick = run && (r_cnt == CNT_TC);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (run) begin
         r_cnt <= tick ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for mux4: latches a word, steps select 0..3 with a dwell per step,
// samples y at the end of each dwell and returns the reconstructed word.
module mux4_scan_ctrl
   import mux4_scan_ctrl_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              enable,
   output logic [SEL_W-1:0]  signal,
   output logic [DATA_W-1:0] data,
   input  logic              y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_word,
   output logic              out_match
);

   // state   | meaning
   // IDLE    | waiting for an input word, in_ready high, mux4 disabled
   // SCAN    | mux4 enabled, select stepping 0..3, y sampled at end of each dwell
   // DONE    | word captured; out_valid raised one cycle after entry, held until out_ready

   state_e              r_state;
   state_e              w_state_nxt;
   logic                w_accept;
   logic                w_out_hs;
   logic                w_tick;
   logic                w_last;
   logic                w_run;
   logic                r_in_ready;
   logic                r_enable;
   logic [SEL_W-1:0]    r_signal;
   logic [DATA_W-1:0]   r_data;
   logic [DATA_W-1:0]   r_capture;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_word;
   logic                r_out_match;

   assign w_run  = (r_state == ST_SCAN);
   assign w_last = w_tick && (r_signal == SEL_LAST);

   dwell_timer #(
      .DWELL (DWELL)
   ) u_dwell_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_accept),
      .run  (w_run),
      .tick (w_tick)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_out_hs    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (in_valid && r_in_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (r_out_valid && out_ready) begin
               w_out_hs    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_enable    <= ENABLE_OFF;
         r_signal    <= '0;
         r_data      <= '0;
         r_capture   <= '0;
         r_out_valid <= 1'b0;
         r_out_word  <= '0;
         r_out_match <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt == ST_IDLE);
         r_enable   <= (w_state_nxt == ST_SCAN) ? ENABLE_ON : ENABLE_OFF;

         if (w_accept) begin
            r_data    <= in_data;
            r_signal  <= '0;
            r_capture <= '0;
         end

         if (w_run && w_tick) begin
            r_capture[r_signal] <= y;
            if (!w_last) begin
               r_signal <= r_signal + 1'b1;
            end
         end

         // publish one cycle after entering DONE so the last sample is included
         if ((r_state == ST_DONE) && !r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_word  <= r_capture;
            r_out_match <= (r_capture == r_data);
         end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign enable    = r_enable;
   assign signal    = r_signal;
   assign data      = r_data;
   assign out_valid = r_out_valid;
   assign out_word  = r_out_word;
   assign out_match = r_out_match;

endmodule
